// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with single-cycle ops and an iterative
// restoring divider. Results and class flags are held in an output register
// that stays stable under backpressure.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] ALU_OUT_HI,
  output logic             Arith_Flag,
  output logic             Logic_Flag,
  output logic             CMP_Flag,
  output logic             Shift_Flag,
  output logic             Div_Zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_XNOR = 4'd9;
  localparam logic [3:0] OP_EQ   = 4'd10;
  localparam logic [3:0] OP_GT   = 4'd11;
  localparam logic [3:0] OP_LT   = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_SHL  = 4'd14;

  typedef enum logic {IDLE, DIV} state_t;

  state_t             state;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   rem_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   c_lo;
  logic [WIDTH-1:0]   c_hi;
  logic [3:0]         c_flags;
  logic               c_dz;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     trial_sub;
  logic               take;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   dvd_nxt;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);

  // Single-cycle result; flag vector is {arith, logic, cmp, shift}
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    prod    = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    c_lo    = '0;
    c_hi    = '0;
    c_flags = '0;
    c_dz    = 1'b0;
    case (ALU_FUN)
      OP_ADD:  begin c_lo = sum[WIDTH-1:0];  c_hi = {{(WIDTH-1){1'b0}}, sum[WIDTH]};  c_flags = 4'b1000; end
      OP_SUB:  begin c_lo = diff[WIDTH-1:0]; c_hi = {{(WIDTH-1){1'b0}}, diff[WIDTH]}; c_flags = 4'b1000; end
      OP_MUL:  begin c_lo = prod[WIDTH-1:0]; c_hi = prod[2*WIDTH-1:WIDTH];            c_flags = 4'b1000; end
      // Only reaches the result register when B is zero
      OP_DIV:  begin c_lo = '1; c_hi = A; c_dz = 1'b1; c_flags = 4'b1000; end
      OP_AND:  begin c_lo = A & B;    c_flags = 4'b0100; end
      OP_OR:   begin c_lo = A | B;    c_flags = 4'b0100; end
      OP_NAND: begin c_lo = ~(A & B); c_flags = 4'b0100; end
      OP_NOR:  begin c_lo = ~(A | B); c_flags = 4'b0100; end
      OP_XOR:  begin c_lo = A ^ B;    c_flags = 4'b0100; end
      OP_XNOR: begin c_lo = ~(A ^ B); c_flags = 4'b0100; end
      OP_EQ:   begin c_lo = (A == B) ? WIDTH'(1) : '0; c_flags = 4'b0010; end
      OP_GT:   begin c_lo = (A > B)  ? WIDTH'(2) : '0; c_flags = 4'b0010; end
      OP_LT:   begin c_lo = (A < B)  ? WIDTH'(3) : '0; c_flags = 4'b0010; end
      OP_SHR:  begin c_lo = {1'b0, A[WIDTH-1:1]}; c_flags = 4'b0001; end
      OP_SHL:  begin c_lo = {A[WIDTH-2:0], 1'b0}; c_hi = {{(WIDTH-1){1'b0}}, A[WIDTH-1]}; c_flags = 4'b0001; end
      default: begin c_lo = '0; end
    endcase
  end

  // One restoring shift-subtract step; quotient bits shift into the dividend register
  always_comb begin
    trial     = {rem_q, dvd_q[WIDTH-1]};
    trial_sub = trial - {1'b0, dvs_q};
    take      = (trial >= {1'b0, dvs_q});
    rem_nxt   = take ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_nxt   = {dvd_q[WIDTH-2:0], take};
  end

  // Control FSM, divider datapath and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      ALU_OUT    <= '0;
      ALU_OUT_HI <= '0;
      Arith_Flag <= 1'b0;
      Logic_Flag <= 1'b0;
      CMP_Flag   <= 1'b0;
      Shift_Flag <= 1'b0;
      Div_Zero   <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (ALU_FUN == OP_DIV && B != '0) begin
              dvd_q <= A;
              dvs_q <= B;
              rem_q <= '0;
              cnt_q <= '0;
              state <= DIV;
            end else begin
              ALU_OUT    <= c_lo;
              ALU_OUT_HI <= c_hi;
              Arith_Flag <= c_flags[3];
              Logic_Flag <= c_flags[2];
              CMP_Flag   <= c_flags[1];
              Shift_Flag <= c_flags[0];
              Div_Zero   <= c_dz;
              out_valid  <= 1'b1;
            end
          end
        end
        DIV: begin
          dvd_q <= dvd_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + CW'(1);
          // Final iteration writes straight into the result register so the
          // divide completes WIDTH edges after acceptance
          if (cnt_q == LAST) begin
            ALU_OUT    <= dvd_nxt;
            ALU_OUT_HI <= rem_nxt;
            Arith_Flag <= 1'b1;
            Logic_Flag <= 1'b0;
            CMP_Flag   <= 1'b0;
            Shift_Flag <= 1'b0;
            Div_Zero   <= 1'b0;
            out_valid  <= 1'b1;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe at WIDTH=16 and
// WIDTH=8 against an arithmetic reference model.
module tb_alu_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv, ir, ov, ordy;
  logic [15:0] a16, b16, lo16, hi16;
  logic [3:0]  f16;
  logic        af, lf, cf, sf, dz;

  logic        iv8, ir8, ov8, ordy8;
  logic [7:0]  a8, b8, lo8, hi8;
  logic [3:0]  f8;
  logic        af8, lf8, cf8, sf8, dz8;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
    logic [3:0]  fl;
    logic        dz;
  } exp_t;

  alu_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .A(a16), .B(b16),
    .ALU_FUN(f16), .out_valid(ov), .out_ready(ordy), .ALU_OUT(lo16), .ALU_OUT_HI(hi16),
    .Arith_Flag(af), .Logic_Flag(lf), .CMP_Flag(cf), .Shift_Flag(sf), .Div_Zero(dz)
  );

  alu_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .ALU_FUN(f8), .out_valid(ov8), .out_ready(ordy8), .ALU_OUT(lo8), .ALU_OUT_HI(hi8),
    .Arith_Flag(af8), .Logic_Flag(lf8), .CMP_Flag(cf8), .Shift_Flag(sf8), .Div_Zero(dz8)
  );

  // Reference: plain arithmetic on unsigned values, masked to w bits
  function automatic exp_t model(input int unsigned w, input logic [3:0] f,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [63:0] m;
    logic [63:0] t;
    m = (64'd1 << w) - 64'd1;
    e = '0;
    case (f)
      4'd0:  begin t = a + b; e.lo = t & m; e.hi = t >> w; end
      4'd1:  begin e.lo = (a - b) & m; e.hi = (a < b) ? 64'd1 : 64'd0; end
      4'd2:  begin t = a * b; e.lo = t & m; e.hi = (t >> w) & m; end
      4'd3:  begin
        if (b == 0) begin e.lo = m; e.hi = a; e.dz = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
      4'd4:  e.lo = a & b;
      4'd5:  e.lo = a | b;
      4'd6:  e.lo = ~(a & b) & m;
      4'd7:  e.lo = ~(a | b) & m;
      4'd8:  e.lo = a ^ b;
      4'd9:  e.lo = ~(a ^ b) & m;
      4'd10: e.lo = (a == b) ? 64'd1 : 64'd0;
      4'd11: e.lo = (a > b) ? 64'd2 : 64'd0;
      4'd12: e.lo = (a < b) ? 64'd3 : 64'd0;
      4'd13: e.lo = a >> 1;
      4'd14: begin e.lo = (a << 1) & m; e.hi = (a >> (w - 1)) & 64'd1; end
      default: e.lo = 64'd0;
    endcase
    if (f <= 4'd3)       e.fl = 4'b1000;
    else if (f <= 4'd9)  e.fl = 4'b0100;
    else if (f <= 4'd12) e.fl = 4'b0010;
    else if (f <= 4'd14) e.fl = 4'b0001;
    else                 e.fl = 4'b0000;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic res16(input string tag, input exp_t e);
    chk({tag, ".valid"}, 64'(ov), 64'd1);
    chk({tag, ".lo"},    64'(lo16), e.lo);
    chk({tag, ".hi"},    64'(hi16), e.hi);
    chk({tag, ".flags"}, 64'({af, lf, cf, sf}), 64'(e.fl));
    chk({tag, ".dz"},    64'(dz), 64'(e.dz));
  endtask

  task automatic res8(input string tag, input exp_t e);
    chk({tag, ".valid"}, 64'(ov8), 64'd1);
    chk({tag, ".lo"},    64'(lo8), e.lo);
    chk({tag, ".hi"},    64'(hi8), e.hi);
    chk({tag, ".flags"}, 64'({af8, lf8, cf8, sf8}), 64'(e.fl));
    chk({tag, ".dz"},    64'(dz8), 64'(e.dz));
  endtask

  // Present an op and hold it until the transfer edge; returns just after that edge
  task automatic issue16(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    int n;
    iv = 1'b1; f16 = f; a16 = a; b16 = b;
    #1;
    n = 0;
    while (!ir && n < 100) begin
      step();
      #1;
      n++;
    end
    chk("issue.ready", 64'(ir), 64'd1);
    step();
    iv = 1'b0;
  endtask

  // Count edges after acceptance until out_valid, and in_ready-low samples meanwhile
  task automatic wait16(output int lat, output int low);
    lat = 0;
    low = 0;
    while (!ov && lat < 200) begin
      if (!ir) low++;
      step();
      lat++;
    end
  endtask

  initial begin
    exp_t e;
    exp_t q[$];
    int   lat, low, n;
    logic seen;

    rst_n = 1'b0;
    iv = 1'b0; ordy = 1'b1; a16 = '0; b16 = '0; f16 = '0;
    iv8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0; f8 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(ov), 64'd0);
    chk("rst.lo", 64'(lo16), 64'd0);
    chk("rst.hi", 64'(hi16), 64'd0);
    chk("rst.flags", 64'({af, lf, cf, sf, dz}), 64'd0);
    chk("rst.w8_out_valid", 64'(ov8), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rst.in_ready", 64'(ir), 64'd1);

    // Back-to-back single-cycle ops with out_ready high
    ordy = 1'b1;
    iv = 1'b1; f16 = 4'd0; a16 = 16'hFFFF; b16 = 16'h0001;
    #1;
    chk("b2b.ready", 64'(ir), 64'd1);
    step();
    res16("b2b.add", model(16, 4'd0, 64'hFFFF, 64'h0001));
    f16 = 4'd2; a16 = 16'h1234; b16 = 16'h0100;
    step();
    res16("b2b.mul", model(16, 4'd2, 64'h1234, 64'h0100));
    f16 = 4'd11; a16 = 16'd5; b16 = 16'd9;
    step();
    res16("b2b.gt", model(16, 4'd11, 64'd5, 64'd9));
    iv = 1'b0;
    step();
    chk("b2b.retired", 64'(ov), 64'd0);

    // Iterative divide
    issue16(4'd3, 16'd1000, 16'd7);
    wait16(lat, low);
    chk("div.cycles", 64'(lat + 1), 64'd17);
    chk("div.in_ready_low", 64'(low), 64'd16);
    res16("div", model(16, 4'd3, 64'd1000, 64'd7));
    step();

    // Divide by zero: single-cycle path
    issue16(4'd3, 16'h00AB, 16'h0000);
    wait16(lat, low);
    chk("dz.cycles", 64'(lat + 1), 64'd1);
    res16("dz", model(16, 4'd3, 64'h00AB, 64'd0));
    step();

    // Backpressure: result holds while a second op waits
    ordy = 1'b0;
    issue16(4'd4, 16'hF0F0, 16'hFF00);
    e = model(16, 4'd4, 64'hF0F0, 64'hFF00);
    iv = 1'b1; f16 = 4'd5; a16 = 16'h0F0F; b16 = 16'h00FF;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp.in_ready%0d", i), 64'(ir), 64'd0);
      res16($sformatf("bp.hold%0d", i), e);
      step();
    end
    ordy = 1'b1;
    #1;
    chk("bp.ready_on_release", 64'(ir), 64'd1);
    step();
    res16("bp.second", model(16, 4'd5, 64'h0F0F, 64'h00FF));
    iv = 1'b0;
    step();
    chk("bp.retired", 64'(ov), 64'd0);

    // Reset mid-divide aborts the operation
    issue16(4'd3, 16'd100, 16'd7);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("rstdiv.out_valid", 64'(ov), 64'd0);
    chk("rstdiv.lo", 64'(lo16), 64'd0);
    chk("rstdiv.hi", 64'(hi16), 64'd0);
    chk("rstdiv.flags", 64'({af, lf, cf, sf, dz}), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rstdiv.in_ready", 64'(ir), 64'd1);
    seen = 1'b0;
    repeat (30) begin
      if (ov) seen = 1'b1;
      step();
    end
    chk("rstdiv.no_result", 64'(seen), 64'd0);

    // Randomized traffic against an in-order scoreboard
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      f16  = 4'($urandom);
      a16  = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b16 = 16'd0;
        1:       b16 = 16'($urandom_range(1, 15));
        2:       b16 = a16;
        default: b16 = 16'($urandom);
      endcase
      ordy = ($urandom_range(0, 3) != 0);
      #1;
      if (ov) begin
        if (q.size() == 0) chk("rand.spurious", 64'(ov), 64'd0);
        else begin
          res16("rand", q[0]);
          if (ordy) void'(q.pop_front());
        end
      end
      if (iv && ir) q.push_back(model(16, f16, 64'(a16), 64'(b16)));
      step();
    end
    iv = 1'b0;
    ordy = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      #1;
      if (ov) begin
        res16("rand.drain", q[0]);
        void'(q.pop_front());
      end
      step();
      n++;
    end
    chk("rand.pending", 64'(q.size()), 64'd0);

    // WIDTH=8 instance
    iv8 = 1'b1; f8 = 4'd14; a8 = 8'h81; b8 = 8'h00;
    #1;
    chk("w8.shl.ready", 64'(ir8), 64'd1);
    step();
    iv8 = 1'b0;
    res8("w8.shl", model(8, 4'd14, 64'h81, 64'd0));
    step();
    iv8 = 1'b1; f8 = 4'd3; a8 = 8'd200; b8 = 8'd3;
    #1;
    chk("w8.div.ready", 64'(ir8), 64'd1);
    step();
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 100) begin
      step();
      lat++;
    end
    chk("w8.div.cycles", 64'(lat + 1), 64'd9);
    res8("w8.div", model(8, 4'd3, 64'd200, 64'd3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's 16-bit registered ALU. Accepts one operation per transfer on a valid/ready input channel, computes single-cycle ops in one clock and unsigned division iteratively over WIDTH clocks, and presents a registered result with class flags on a valid/ready output channel. Sits between an operand-issue stage and a result-writeback stage; backpressure from writeback stalls issue.

## Interface
- WIDTH, 16: operand and result width; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands and opcode valid.
- in_ready  out  1  block can accept an operation this cycle.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned.
- ALU_FUN  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- ALU_OUT  out  WIDTH  primary result.
- ALU_OUT_HI  out  WIDTH  product high half (mul), remainder (div), else 0.
- Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag  out  1 each  opcode-class flags, registered with the result.
- Div_Zero  out  1  division with B == 0.

## Operation
- Opcodes: 0000 A+B (carry out to ALU_OUT_HI[0]); 0001 A-B (mod 2^WIDTH, borrow to ALU_OUT_HI[0]); 0010 A*B full 2*WIDTH product, low to ALU_OUT, high to ALU_OUT_HI; 0011 A/B, quotient to ALU_OUT, remainder to ALU_OUT_HI; 0100 AND; 0101 OR; 0110 NAND; 0111 NOR; 1000 XOR; 1001 XNOR; 1010 ALU_OUT = (A==B) ? 1 : 0; 1011 (A>B) ? 2 : 0; 1100 (A<B) ? 3 : 0; 1101 A>>1 logical; 1110 A<<1, bit shifted out to ALU_OUT_HI[0]; 1111 all result bits 0.
- Compare ops always write 0 on a false compare; no result holds a stale value.
- Flags: Arith for 0000-0011, Logic for 0100-1001, CMP for 1010-1100, Shift for 1101-1110; none for 1111. Exactly one flag (or none) set per result.
- FSM states: IDLE, DIV.
  - IDLE: transfer when in_valid && in_ready. Non-divide op, or divide with B==0: result register loads, out_valid=1 next cycle, stay IDLE. Divide with B!=0: latch A, B, clear remainder and counter, go DIV.
  - DIV: restoring shift-subtract, one quotient bit per cycle, MSB first; counter width $clog2(WIDTH)+1. After WIDTH iterations load result register, set out_valid, return to IDLE.
- Divide by zero: ALU_OUT = all ones, ALU_OUT_HI = A, Div_Zero=1, Arith_Flag=1, single-cycle latency.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Low throughout DIV.
- Output register: when out_valid && !out_ready, ALU_OUT, ALU_OUT_HI, all flags and out_valid hold stable. out_valid clears after handshake unless a new result loads the same cycle.
- A, B, ALU_FUN are sampled only on an input transfer; changes at other times have no effect.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, ALU_OUT=0, ALU_OUT_HI=0, all flags=0, Div_Zero=0, divider registers=0. in_ready=1 from the first edge after release.
- Reset mid-divide aborts the operation; no result is produced for it.
- Single-cycle ops: accepted at edge N, out_valid at N+1. With out_ready held high, throughput is one op per cycle.
- Divide with B!=0: accepted at N, out_valid at N+WIDTH+1; in_ready=0 from N+1 until the edge at which out_valid rises; the next op can be accepted at that cycle if out_ready=1.
- Simultaneous output handshake and input transfer in IDLE: old result retires and new result loads on the same edge; out_valid stays 1.
- Multiply is combinational into the result register; the 2*WIDTH product must meet one cycle at target frequency.

## Test plan
- Reset mid-divide: WIDTH=16, issue 0011 A=100 B=7, assert rst_n low at cycle 5 -> all outputs 0, in_ready=1 after release, no out_valid.
- Back-to-back, out_ready=1: 0000 A=0xFFFF B=1, 0010 A=0x1234 B=0x0100, 1011 A=5 B=9 -> ALU_OUT/HI = 0x0000/0x0001, 0x3400/0x0012, 0x0000/0; flags Arith, Arith, CMP; out_valid on three consecutive cycles.
- Divide: 0011 A=1000 B=7 -> after exactly 17 cycles ALU_OUT=142, ALU_OUT_HI=6, Arith_Flag=1, Div_Zero=0; in_ready low for 16 cycles.
- Divide by zero: 0011 A=0x00AB B=0 -> next cycle ALU_OUT=0xFFFF, ALU_OUT_HI=0x00AB, Div_Zero=1.
- Backpressure: 0100 A=0xF0F0 B=0xFF00 with out_ready=0 for 4 cycles -> ALU_OUT=0xF000, Logic_Flag=1 held stable, in_ready=0; second op accepted on the cycle out_ready rises.
- Parameter sweep WIDTH=8: 1110 A=0x81 -> ALU_OUT=0x02, ALU_OUT_HI=1, Shift_Flag=1; 0011 A=200 B=3 -> 66 r 2 after 9 cycles.
